// File: rtl/lcd_sprite_engine_pkg.sv
// lcd_pkg: shared constants and the FSM state type for the PCD8544 sprite engine.
//   CMD_*      : PCD8544 command opcodes used by init and cursor placement
//   *_DEF      : default display geometry (84 columns x 6 banks)
//   state_e    : engine FSM states, also exported on the debug port
package lcd_pkg;
    localparam logic [7:0] CMD_FUNC_EXT    = 8'h21;
    localparam logic [7:0] CMD_FUNC_BASIC  = 8'h20;
    localparam logic [7:0] CMD_DISP_NORMAL = 8'h0C;
    localparam logic [7:0] CMD_SET_Y       = 8'h40;
    localparam logic [7:0] CMD_SET_X       = 8'h80;

    localparam int LCD_COLS_DEF  = 84;
    localparam int LCD_BANKS_DEF = 6;
    localparam int INIT_LEN      = 6;

    typedef enum logic [3:0] {
        ST_INIT,
        ST_CLEAR,
        ST_IDLE,
        ST_CHECK,
        ST_SETY,
        ST_SETX,
        ST_FETCH,
        ST_LOAD,
        ST_SEND
    } state_e;
endpackage

// File: rtl/lcd_sprite_engine_if.sv
// Request and byte-stream bundle between the client (master) and the sprite engine (slave).
//   req_*  : draw request, transferred on the cycle where req_valid & req_ready are both high
//   tx_*   : byte stream towards the SPI byte master, transferred when tx_valid & tx_ready
// Handshake: a producer holds valid and its payload unchanged until the cycle where the
// consumer's ready is also high; that cycle is the transfer, nothing else counts.
interface lcd_sprite_engine_if #(
    parameter int ID_W = 3
);
    logic            req_valid;
    logic            req_ready;
    logic [ID_W-1:0] req_id;
    logic [6:0]      req_x;
    logic [2:0]      req_y;
    logic            req_mirror;
    logic            req_clear;

    logic            tx_valid;
    logic            tx_ready;
    logic [7:0]      tx_byte;
    logic            tx_dc;

    modport master (
        output req_valid, req_id, req_x, req_y, req_mirror, req_clear,
        input  req_ready,
        input  tx_valid, tx_byte, tx_dc,
        output tx_ready
    );

    modport slave (
        input  req_valid, req_id, req_x, req_y, req_mirror, req_clear,
        output req_ready,
        output tx_valid, tx_byte, tx_dc,
        input  tx_ready
    );
endinterface

// File: rtl/lcd_sprite_engine_init_seq.sv
// lcd_init_seq: combinational table mapping an init step index to its command byte.
//   idx : step 0..5 (others return 0x00)
//   cmd : command byte for that step
module lcd_init_seq
    import lcd_pkg::*;
#(
    parameter logic [7:0] VOP = 8'h90
) (
    input  logic [2:0] idx,
    output logic [7:0] cmd
);
    always_comb begin
        cmd = 8'h00;
        case (idx)
            3'd0:    cmd = CMD_FUNC_EXT;
            3'd1:    cmd = VOP;
            3'd2:    cmd = CMD_FUNC_BASIC;
            3'd3:    cmd = CMD_DISP_NORMAL;
            3'd4:    cmd = CMD_SET_Y;
            3'd5:    cmd = CMD_SET_X;
            default: cmd = 8'h00;
        endcase
    end
endmodule

// File: rtl/lcd_sprite_engine.sv
// lcd_sprite_engine: PCD8544 sprite renderer. After reset it sends the init commands and
// clears the whole display, then draws (or erases) sprites from an external sync ROM with
// right/bottom clipping and optional horizontal mirroring.
//   clk, reset : clock, synchronous active-low reset
//   bus        : request + tx byte stream (slave side)
//   rom_addr   : sprite ROM address; rom_data returns one cycle later
//   init_done  : set once init+clear finished, cleared only by reset
//   busy       : not in IDLE
//   req_err    : one-cycle pulse when an accepted request had no visible bank
//   state_dbg  : current FSM state
module lcd_sprite_engine
    import lcd_pkg::*;
#(
    parameter int         SPR_W     = 8,
    parameter int         SPR_BANKS = 2,
    parameter int         N_SPR     = 8,
    parameter int         LCD_COLS  = LCD_COLS_DEF,
    parameter int         LCD_BANKS = LCD_BANKS_DEF,
    parameter logic [7:0] VOP       = 8'h90,
    parameter int         ID_W      = $clog2(N_SPR),
    parameter int         AW        = $clog2(N_SPR * SPR_W * SPR_BANKS)
) (
    input  logic                 clk,
    input  logic                 reset,
    lcd_sprite_engine_if.slave   bus,
    output logic [AW-1:0]        rom_addr,
    input  logic [7:0]           rom_data,
    output logic                 init_done,
    output logic                 busy,
    output logic                 req_err,
    output state_e               state_dbg
);
    localparam int CLEAR_LEN = LCD_COLS * LCD_BANKS;
    localparam int NW = $clog2(CLEAR_LEN + 1);
    localparam int CW = $clog2(SPR_W + 1);
    localparam int BW = $clog2(SPR_BANKS + 1);

    localparam logic [7:0]    COLS_L   = 8'(LCD_COLS);
    localparam logic [3:0]    BANKS_L  = 4'(LCD_BANKS);
    localparam logic [CW-1:0] SPR_W_L  = CW'(SPR_W);
    localparam logic [BW-1:0] SPR_B_L  = BW'(SPR_BANKS);

    state_e          state_q, state_d;
    logic [NW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   b_q, b_d;
    logic [CW-1:0]   c_q, c_d;
    logic            drawn_q, drawn_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [6:0]      x_q, x_d;
    logic [2:0]      y_q, y_d;
    logic            mirror_q, mirror_d;
    logic            clear_q, clear_d;
    logic            tx_valid_q, tx_valid_d;
    logic [7:0]      tx_byte_q, tx_byte_d;
    logic            tx_dc_q, tx_dc_d;
    logic            init_done_q, init_done_d;
    logic            req_err_q, req_err_d;

    logic            hs;
    logic [2:0]      init_idx;
    logic [7:0]      init_cmd;
    logic [3:0]      row;
    logic [CW-1:0]   c_next;
    logic [7:0]      x_next;
    logic [CW-1:0]   col;

    // While a command is pending the table already points at the following step,
    // so the next byte can be loaded on the same cycle the current one transfers.
    assign init_idx = tx_valid_q ? (cnt_q[2:0] + 3'd1) : cnt_q[2:0];

    lcd_init_seq #(.VOP(VOP)) u_init_seq (
        .idx (init_idx),
        .cmd (init_cmd)
    );

    assign hs     = tx_valid_q & bus.tx_ready;
    assign row    = {1'b0, y_q} + 4'(b_q);
    assign c_next = c_q + CW'(1);
    assign x_next = {1'b0, x_q} + 8'(c_next);
    assign col    = mirror_q ? (SPR_W_L - CW'(1) - c_q) : c_q;

    assign rom_addr = AW'(int'(id_q) * SPR_W * SPR_BANKS + int'(b_q) * SPR_W + int'(col));

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.tx_valid  = tx_valid_q;
    assign bus.tx_byte   = tx_byte_q;
    assign bus.tx_dc     = tx_dc_q;
    assign init_done     = init_done_q;
    assign busy          = (state_q != ST_IDLE);
    assign req_err       = req_err_q;
    assign state_dbg     = state_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            b_q         <= '0;
            c_q         <= '0;
            drawn_q     <= 1'b0;
            id_q        <= '0;
            x_q         <= '0;
            y_q         <= '0;
            mirror_q    <= 1'b0;
            clear_q     <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_byte_q   <= 8'h00;
            tx_dc_q     <= 1'b0;
            init_done_q <= 1'b0;
            req_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            b_q         <= b_d;
            c_q         <= c_d;
            drawn_q     <= drawn_d;
            id_q        <= id_d;
            x_q         <= x_d;
            y_q         <= y_d;
            mirror_q    <= mirror_d;
            clear_q     <= clear_d;
            tx_valid_q  <= tx_valid_d;
            tx_byte_q   <= tx_byte_d;
            tx_dc_q     <= tx_dc_d;
            init_done_q <= init_done_d;
            req_err_q   <= req_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        b_d         = b_q;
        c_d         = c_q;
        drawn_d     = drawn_q;
        id_d        = id_q;
        x_d         = x_q;
        y_d         = y_q;
        mirror_d    = mirror_q;
        clear_d     = clear_q;
        tx_valid_d  = tx_valid_q;
        tx_byte_d   = tx_byte_q;
        tx_dc_d     = tx_dc_q;
        init_done_d = init_done_q;
        req_err_d   = 1'b0;

        case (state_q)
            ST_INIT: begin
                if (!tx_valid_q) begin
                    tx_valid_d = 1'b1;
                    tx_byte_d  = init_cmd;
                    tx_dc_d    = 1'b0;
                end else if (hs) begin
                    if (cnt_q == NW'(INIT_LEN - 1)) begin
                        cnt_d     = '0;
                        tx_byte_d = 8'h00;
                        tx_dc_d   = 1'b1;
                        state_d   = ST_CLEAR;
                    end else begin
                        cnt_d     = cnt_q + NW'(1);
                        tx_byte_d = init_cmd;
                    end
                end
            end
            ST_CLEAR: begin
                if (hs) begin
                    if (cnt_q == NW'(CLEAR_LEN - 1)) begin
                        cnt_d       = '0;
                        tx_valid_d  = 1'b0;
                        init_done_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + NW'(1);
                    end
                end
            end
            ST_IDLE: begin
                if (bus.req_valid) begin
                    id_d     = bus.req_id;
                    x_d      = bus.req_x;
                    y_d      = bus.req_y;
                    mirror_d = bus.req_mirror;
                    clear_d  = bus.req_clear;
                    b_d      = '0;
                    c_d      = '0;
                    drawn_d  = 1'b0;
                    state_d  = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (b_q == SPR_B_L) begin
                    req_err_d = ~drawn_q;
                    state_d   = ST_IDLE;
                end else if (({1'b0, x_q} >= COLS_L) || (row >= BANKS_L)) begin
                    b_d = b_q + BW'(1);
                end else begin
                    drawn_d    = 1'b1;
                    tx_valid_d = 1'b1;
                    tx_byte_d  = CMD_SET_Y | {5'b0, row[2:0]};
                    tx_dc_d    = 1'b0;
                    state_d    = ST_SETY;
                end
            end
            ST_SETY: begin
                if (hs) begin
                    tx_byte_d = CMD_SET_X | {1'b0, x_q};
                    state_d   = ST_SETX;
                end
            end
            ST_SETX: begin
                if (hs) begin
                    tx_valid_d = 1'b0;
                    c_d        = '0;
                    state_d    = ST_FETCH;
                end
            end
            // rom_addr is presented here; the ROM answers during ST_LOAD.
            ST_FETCH: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                tx_valid_d = 1'b1;
                tx_byte_d  = clear_q ? 8'h00 : rom_data;
                tx_dc_d    = 1'b1;
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                if (hs) begin
                    tx_valid_d = 1'b0;
                    if ((c_next == SPR_W_L) || (x_next == COLS_L)) begin
                        c_d     = '0;
                        b_d     = b_q + BW'(1);
                        state_d = ST_CHECK;
                    end else begin
                        c_d     = c_next;
                        state_d = ST_FETCH;
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase
    end
endmodule
